// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - OV7670 capture stage: RGB565 byte pairs to RGB332 frame-buffer writes
//
// Ports:
//   CLK         camera PCLK, all logic on the rising edge
//   RESET_N     asynchronous active-low reset
//   VSYNC       camera VSYNC, high = vertical blank
//   HREF        camera HREF, high = valid line bytes
//   D           camera data byte
//   W_ADDR      frame-buffer write address (y*WIDTH + x)
//   W_DATA      RGB332 pixel
//   W_EN        single-cycle write strobe
//   FRAME_DONE  one-cycle pulse when a captured frame ends
//   LINE_ERR    sticky: a line ended with an odd byte count
//   BUSY        high while capturing (ACTIVE state)
//
// Optional build macro CAPTURE_TEST_PATTERN_EN: W_DATA carries eight vertical
// colour bars instead of camera data; timing, addresses and flags unchanged.

module cam_capture_ctrl #(
    parameter int WIDTH  = 176,
    parameter int HEIGHT = 144,
    parameter int ADDR_W = 15
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        D,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        W_DATA,
    output logic              W_EN,
    output logic              FRAME_DONE,
    output logic              LINE_ERR,
    output logic              BUSY
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);

    localparam logic [XW-1:0] X_END  = XW'(WIDTH);
    localparam logic [YW-1:0] Y_END  = YW'(HEIGHT);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_VBLANK = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

`ifdef CAPTURE_TEST_PATTERN_EN
    localparam int BAR_W  = WIDTH / 8;
    localparam int BCW    = $clog2(BAR_W + 1);
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);

    function automatic logic [7:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 8'hFF;
            3'd1:    bar_color = 8'hFC;
            3'd2:    bar_color = 8'h1F;
            3'd3:    bar_color = 8'h1C;
            3'd4:    bar_color = 8'hE3;
            3'd5:    bar_color = 8'hE0;
            3'd6:    bar_color = 8'h03;
            default: bar_color = 8'h00;
        endcase
    endfunction

    // Bar index tracked incrementally alongside x so no divider is needed.
    logic [BCW-1:0] bar_cnt;
    logic [2:0]     bar_idx;
`endif

    logic [1:0]        state;
    logic              vsync_q;
    logic              href_q;
    logic              phase;
    // Only the bits of the first byte that reach the RGB332 pixel are held.
    logic [5:0]        b1;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] line_base;

    logic vs_rise;
    logic vs_fall;
    logic href_fall;
    logic byte_ok;

    assign vs_rise   = VSYNC & ~vsync_q;
    assign vs_fall   = ~VSYNC & vsync_q;
    assign href_fall = href_q & ~HREF;
    // Bytes arriving during vertical blank are not part of the image.
    assign byte_ok   = HREF & ~VSYNC;

    assign BUSY = (state == S_ACTIVE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            phase      <= 1'b0;
            b1         <= '0;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            W_ADDR     <= '0;
            W_DATA     <= '0;
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;
            LINE_ERR   <= 1'b0;
`ifdef CAPTURE_TEST_PATTERN_EN
            bar_cnt    <= '0;
            bar_idx    <= '0;
`endif
        end else begin
            vsync_q    <= VSYNC;
            href_q     <= HREF;
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;

            case (state)
                // Reset leaves vsync_q low, so a frame already in progress is
                // skipped: we must see VSYNC high here and then its fall.
                S_IDLE: begin
                    if (VSYNC) begin
                        state <= S_VBLANK;
                    end
                end

                S_VBLANK: begin
                    phase     <= 1'b0;
                    b1        <= '0;
                    x         <= '0;
                    y         <= '0;
                    line_base <= '0;
                    LINE_ERR  <= 1'b0;
`ifdef CAPTURE_TEST_PATTERN_EN
                    bar_cnt   <= '0;
                    bar_idx   <= '0;
`endif
                    if (vs_fall) begin
                        state <= S_ACTIVE;
                    end
                end

                S_ACTIVE: begin
                    if (vs_rise) begin
                        // Frame end wins over a coincident line end; the
                        // counters are cleared in VBLANK anyway.
                        FRAME_DONE <= 1'b1;
                        LINE_ERR   <= 1'b0;
                        state      <= S_VBLANK;
                    end else if (byte_ok) begin
                        phase <= ~phase;
                        if (!phase) begin
                            b1 <= {D[7:5], D[2:0]};
                        end else if (x != X_END) begin
                            if (y != Y_END) begin
                                W_EN   <= 1'b1;
                                W_ADDR <= line_base + ADDR_W'(x);
`ifdef CAPTURE_TEST_PATTERN_EN
                                W_DATA <= bar_color(bar_idx);
`else
                                W_DATA <= {b1, D[4:3]};
`endif
                            end
                            x <= x + 1'b1;
`ifdef CAPTURE_TEST_PATTERN_EN
                            if (bar_cnt == BAR_LAST) begin
                                bar_cnt <= '0;
                                if (bar_idx != 3'd7) begin
                                    bar_idx <= bar_idx + 1'b1;
                                end
                            end else begin
                                bar_cnt <= bar_cnt + 1'b1;
                            end
`endif
                        end
                    end else if (href_fall) begin
                        // Empty HREF pulses (x == 0) do not count as lines.
                        if (x != '0) begin
                            x <= '0;
`ifdef CAPTURE_TEST_PATTERN_EN
                            bar_cnt <= '0;
                            bar_idx <= '0;
`endif
                            if (y != Y_END) begin
                                y <= y + 1'b1;
                            end
                            // line_base stops at the last stored line so it
                            // never leaves the buffer; writes stop via y.
                            if (y < Y_LAST) begin
                                line_base <= line_base + ADDR_W'(WIDTH);
                            end
                        end
                        if (phase) begin
                            phase    <= 1'b0;
                            LINE_ERR <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - directed self-checking bench for cam_capture_ctrl

module tb_cam_capture_ctrl;

    localparam int WIDTH  = 176;
    localparam int HEIGHT = 144;
    localparam int ADDR_W = 15;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              vsync = 1'b0;
    logic              href  = 1'b0;
    logic [7:0]        d     = 8'h00;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_data;
    logic              w_en;
    logic              frame_done;
    logic              line_err;
    logic              busy;

    always #5 clk = ~clk;

    cam_capture_ctrl #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .VSYNC      (vsync),
        .HREF       (href),
        .D          (d),
        .W_ADDR     (w_addr),
        .W_DATA     (w_data),
        .W_EN       (w_en),
        .FRAME_DONE (frame_done),
        .LINE_ERR   (line_err),
        .BUSY       (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    int exp_addr[$];
    int exp_data[$];
    int wen_cnt    = 0;
    int fd_cnt     = 0;
    int max_addr   = 0;
    int last_addr  = -1;
    int first_addr = -1;
    bit first_seen = 1'b0;
    int ym         = 0;
    bit model_en   = 1'b1;

    function automatic int exp_pixel(input int xp, input int cam_pix);
`ifdef CAPTURE_TEST_PATTERN_EN
        case (xp / (WIDTH / 8))
            0:       return 'hFF;
            1:       return 'hFC;
            2:       return 'h1F;
            3:       return 'h1C;
            4:       return 'hE3;
            5:       return 'hE0;
            6:       return 'h03;
            default: return 'h00;
        endcase
`else
        return cam_pix + 0 * xp;
`endif
    endfunction

    // Outputs are registered on posedge, so sample on the falling edge.
    always @(negedge clk) begin
        if (w_en) begin
            wen_cnt++;
            last_addr = int'(w_addr);
            if (int'(w_addr) > max_addr) max_addr = int'(w_addr);
            if (!first_seen) begin
                first_seen = 1'b1;
                first_addr = int'(w_addr);
            end
            if (exp_addr.size() == 0) begin
                check("unexpected_w_en", 1, 0);
            end else begin
                check("w_addr", int'(w_addr), exp_addr.pop_front());
                check("w_data", int'(w_data), exp_data.pop_front());
            end
        end
        if (frame_done) fd_cnt++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_bytes(input int nbytes, input logic [7:0] b1,
                              input logic [7:0] b2, input int cam_pix);
        for (int i = 0; i < nbytes; i++) begin
            href = 1'b1;
            d    = (i % 2 == 0) ? b1 : b2;
            if ((i % 2 == 1) && model_en && (i / 2) < WIDTH && ym < HEIGHT) begin
                exp_addr.push_back(ym * WIDTH + i / 2);
                exp_data.push_back(exp_pixel(i / 2, cam_pix));
            end
            tick();
        end
    endtask

    task automatic send_line(input int nbytes, input logic [7:0] b1,
                             input logic [7:0] b2, input int cam_pix);
        send_bytes(nbytes, b1, b2, cam_pix);
        href = 1'b0;
        d    = 8'h00;
        if (nbytes >= 2) ym++;
        tick();
        tick();
    endtask

    task automatic start_frame();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        ym    = 0;
        repeat (2) tick();
    endtask

    task automatic end_frame();
        vsync = 1'b1;
        repeat (3) tick();
    endtask

    int wen0;
    int fd0;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_w_en", int'(w_en), 0);
        check("rst_w_addr", int'(w_addr), 0);
        check("rst_w_data", int'(w_data), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_line_err", int'(line_err), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", int'(busy), 0);

        // Frame 1: full frame of 0xE0/0x18 -> RGB332 0xE3
        wen_cnt = 0;
        max_addr = 0;
        start_frame();
        check("active_busy", int'(busy), 1);
        for (int l = 0; l < HEIGHT; l++) send_line(352, 8'hE0, 8'h18, 'hE3);
        check("f1_writes", wen_cnt, 25344);
        check("f1_last_addr", last_addr, 25343);
        check("f1_line_err", int'(line_err), 0);
        check("f1_fd_before_end", fd_cnt, 0);
        end_frame();
        check("f1_frame_done", fd_cnt, 1);
        check("f1_busy_vblank", int'(busy), 0);

        // Frame 2: wide line, odd line, overlong frame
        start_frame();
        wen_cnt = 0;
        max_addr = 0;
        send_line(400, 8'hFF, 8'hFF, 'hFF);
        check("wide_writes", wen_cnt, 176);
        check("wide_last_addr", last_addr, 175);
        first_seen = 1'b0;
        send_line(352, 8'h00, 8'h00, 'h00);
        check("after_wide_first_addr", first_addr, 176);
        wen0 = wen_cnt;
        send_line(7, 8'hA5, 8'h08, 'hB5);
        check("odd_line_writes", wen_cnt - wen0, 3);
        check("odd_line_err", int'(line_err), 1);
        first_seen = 1'b0;
        send_line(352, 8'h24, 8'h10, 'h32);
        check("after_odd_first_addr", first_addr, 528);
        check("line_err_sticky", int'(line_err), 1);
        for (int l = 4; l < 140; l++) send_line(4, 8'hE0, 8'h18, 'hE3);
        for (int l = 140; l < 150; l++) send_line(352, 8'hE0, 8'h18, 'hE3);
        check("f2_writes", wen_cnt, 1507);
        check("f2_max_addr", max_addr, 25343);
        check("f2_line_err_held", int'(line_err), 1);
        end_frame();
        check("f2_frame_done", fd_cnt, 2);
        check("f2_line_err_cleared", int'(line_err), 0);

        // Frame 3: VSYNC rises on the same edge that HREF falls
        start_frame();
        send_line(352, 8'hE0, 8'h18, 'hE3);
        send_line(352, 8'hE0, 8'h18, 'hE3);
        send_bytes(10, 8'hE0, 8'h18, 'hE3);
        fd0 = fd_cnt;
        href  = 1'b0;
        vsync = 1'b1;
        repeat (3) tick();
        check("simul_frame_done", fd_cnt - fd0, 1);
        check("simul_busy", int'(busy), 0);

        // Frame 4: reset at line 50, nothing written until a full VBLANK
        start_frame();
        for (int l = 0; l < 50; l++) send_line(4, 8'hE0, 8'h18, 'hE3);
        send_bytes(3, 8'hE0, 8'h18, 'hE3);
        rst_n    = 1'b0;
        model_en = 1'b0;
        tick();
        tick();
        check("midrst_busy", int'(busy), 0);
        rst_n = 1'b1;
        wen0  = wen_cnt;
        send_bytes(100, 8'hE0, 8'h18, 'hE3);
        href = 1'b0;
        tick();
        for (int l = 0; l < 3; l++) send_line(20, 8'hE0, 8'h18, 'hE3);
        check("midrst_no_w_en", wen_cnt - wen0, 0);
        check("midrst_idle", int'(busy), 0);
        model_en   = 1'b1;
        first_seen = 1'b0;
        start_frame();
        send_line(352, 8'h55, 8'h10, 'h56);
        check("midrst_first_addr", first_addr, 0);
        end_frame();

        check("queue_drained", exp_addr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Camera-side capture stage between OV7670 parallel bus (PCLK domain) and the dual-port M9K frame buffer write port.
- Assembles byte pairs of RGB565 into RGB332 pixels and generates the frame-buffer write address and write strobe.
- Tracks frame and line boundaries from VSYNC/HREF and clips the image to WIDTH x HEIGHT.
- Buffer read side (VGA driver, image processor) is unaffected.

Parameters:
- WIDTH, 176, pixels per line stored
- HEIGHT, 144, lines per frame stored
- ADDR_W, 15, write address width; WIDTH*HEIGHT must be <= 2^ADDR_W

Ports:
- CLK  in  1  camera PCLK; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- VSYNC  in  1  camera VSYNC, high = vertical blank
- HREF  in  1  camera HREF, high = valid line bytes
- D  in  8  camera data byte
- W_ADDR  out  ADDR_W  frame-buffer write address
- W_DATA  out  8  RGB332 pixel
- W_EN  out  1  single-cycle write strobe
- FRAME_DONE  out  1  one-cycle pulse at end of a captured frame
- LINE_ERR  out  1  sticky flag: a line had an odd byte count
- BUSY  out  1  high while in ACTIVE state

Behaviour:
- Reset, asynchronous on RESET_N low:
  - All outputs 0; state IDLE.
  - x, y, address and byte-phase counters cleared; held byte cleared.
  - A reset mid-frame discards the partial frame. Capture resumes only after the next full VBLANK.
- States:
  - IDLE: wait for VSYNC=1, then go to VBLANK.
  - VBLANK: counters cleared; LINE_ERR cleared. On VSYNC falling (sampled 1 then 0), go to ACTIVE.
  - ACTIVE: capture. On VSYNC rising, pulse FRAME_DONE for 1 cycle and go to VBLANK.
- Byte assembly:
  - On each edge in ACTIVE with HREF=1, phase toggles.
  - Phase 0: latch byte b1.
  - Phase 1: form pixel {b1[7:5], b1[2:0], D[4:3]}.
- Write, for pixels with x<WIDTH and y<HEIGHT:
  - On the edge after the phase-1 byte, W_EN=1 for exactly 1 cycle.
  - W_DATA = pixel; W_ADDR = y*WIDTH + x.
  - Latency: 1 cycle from the phase-1 byte edge to the registered strobe.
- Address generation:
  - Maintained incrementally as a line-base register plus x; no multiplier.
  - line_base += WIDTH per completed line.
- Clipping:
  - Pixels with x>=WIDTH are not written; x saturates at WIDTH.
  - Lines with y>=HEIGHT are not written; y saturates at HEIGHT.
  - Address never exceeds WIDTH*HEIGHT-1.
- Line end, HREF falling while ACTIVE:
  - If x>0, y increments and x=0.
  - If phase=1 (odd byte count), the dangling byte is dropped, LINE_ERR is set, and phase resets to 0.
  - HREF pulses with zero bytes do not advance y.
- Simultaneous events:
  - VSYNC rising on the same edge as HREF falling: frame end takes priority; y is not incremented; FRAME_DONE still pulses.
  - HREF high while VSYNC high: ignored.
- BUSY = (state==ACTIVE).
- LINE_ERR holds until the next VBLANK entry or reset.

Optional Feature:
- Macro: CAPTURE_TEST_PATTERN_EN.
- Defined:
  - W_DATA is replaced by vertical colour bars: bar index = x / (WIDTH/8).
  - Bar colours: 0xFF, 0xFC, 0x1F, 0x1C, 0xE3, 0xE0, 0x03, 0x00.
  - Camera D ignored for data only; timing, W_EN, W_ADDR and all flags are identical to normal capture.
- Undefined: W_DATA from camera bytes as above.

Test Plan:
- Reset, then VSYNC high 3 cycles, low, 144 lines of 352 bytes (b1=0xE0, b2=0x18):
  - 25344 W_EN pulses, W_DATA=0xE3.
  - Last W_ADDR=25343.
  - FRAME_DONE pulses once on VSYNC rise; LINE_ERR=0.
- Line of 400 bytes:
  - Only 176 writes, addresses line_base..line_base+175.
  - The next line starts at line_base+176.
- 150 lines sent:
  - Lines 144..149 produce no W_EN; W_ADDR max 25343.
- Line of 7 bytes:
  - 3 writes; LINE_ERR=1 and stays 1 until VBLANK.
  - Next line first write at x=0 with phase correct.
- RESET_N asserted at line 50, then released mid-frame:
  - No W_EN until VSYNC high->low seen.
  - First write of the next frame at W_ADDR=0.
- CAPTURE_TEST_PATTERN_EN defined, full frame:
  - x=0..21 write 0xFF, x=22..43 write 0xFC, ..., x=154..175 write 0x00.
